// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
// Holds the FSM state encoding, default widths and default arbitration limits.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_LEN         = 32;
    localparam int unsigned DATA_LEN         = 32;
    localparam int unsigned ARB_STARVE_LIMIT = 4;
    localparam int unsigned ARB_TIMEOUT      = 64;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating up-counter with synchronous clear/load and a terminal-count flag.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (count -> 0)
//   clr         synchronous clear (highest priority)
//   load        synchronous load of load_val
//   inc         increment by one; holds once count == LIMIT
//   tc_c        combinational flag, count == LIMIT
module arb_timeout_counter #(
    parameter int unsigned LIMIT = 63,
    localparam int unsigned W    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         tc_c
);

    logic [W-1:0] count;

    assign tc_c = (count == W'(LIMIT));

    // Count register; saturates at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !tc_c) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction
// fetch (read-only) and the load/store stage. Data wins ties unless the fetch
// has been passed over STARVE_LIMIT times in a row; a watchdog aborts any
// transaction that sees no m_ready for TIMEOUT cycles.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (level) and address
//   if_done/if_rdata               fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata      data request (level), store flag, address, data
//   d_done/d_rdata                 data completion pulse and load data
//   err                            timeout pulse, coincident with the done pulse
//   m_req/m_we/m_addr/m_wdata      shared memory command, held until m_ready
//   m_rdata/m_ready                shared memory response
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_LEN,
    parameter int unsigned DATA_W       = DATA_LEN,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready
);

    arb_state_t state, state_nxt;

    logic              m_req_nxt;
    logic              m_we_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [DATA_W-1:0] m_wdata_nxt;
    logic              if_done_nxt;
    logic              d_done_nxt;
    logic              err_nxt;
    logic [DATA_W-1:0] if_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;

    logic timer_clr, timer_inc, timer_tc;
    logic starve_clr, starve_inc, starve_tc;
    logic if_elig, d_elig, pick_i, pick_d;

    // A requester is masked while its own done pulse is visible, so a level
    // request still high in that cycle is not granted a second time.
    assign if_elig = if_req & ~if_done;
    assign d_elig  = d_req & ~d_done;
    assign pick_i  = if_elig & (~d_elig | starve_tc);
    assign pick_d  = d_elig & ~pick_i;

    // Watchdog: terminal count one below TIMEOUT so the abort edge lands
    // exactly TIMEOUT busy cycles after the grant.
    arb_timeout_counter #(
        .LIMIT (TIMEOUT - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (timer_inc),
        .tc_c     (timer_tc)
    );

    // Consecutive data grants taken while a fetch was waiting.
    arb_timeout_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr      (starve_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (starve_inc),
        .tc_c     (starve_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        m_req_nxt    = m_req;
        m_we_nxt     = m_we;
        m_addr_nxt   = m_addr;
        m_wdata_nxt  = m_wdata;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        if_done_nxt  = 1'b0;
        d_done_nxt   = 1'b0;
        err_nxt      = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        starve_clr   = 1'b0;
        starve_inc   = 1'b0;

        case (state)
            ARB_IDLE: begin
                m_req_nxt = 1'b0;
                if (pick_i || pick_d) begin
                    m_req_nxt = 1'b1;
                    timer_clr = 1'b1;
                    if (pick_i) begin
                        m_we_nxt    = 1'b0;
                        m_addr_nxt  = if_addr;
                        m_wdata_nxt = '0;
                        starve_clr  = 1'b1;
                        state_nxt   = ARB_BUSY_I;
                    end else begin
                        m_we_nxt    = d_we;
                        m_addr_nxt  = d_addr;
                        m_wdata_nxt = d_wdata;
                        starve_inc  = if_req;
                        starve_clr  = ~if_req;
                        state_nxt   = ARB_BUSY_D;
                    end
                end
            end

            ARB_BUSY_I, ARB_BUSY_D: begin
                if (m_ready || timer_tc) begin
                    // Completion or abort; an abort returns zero read data.
                    m_req_nxt = 1'b0;
                    err_nxt   = ~m_ready;
                    state_nxt = ARB_IDLE;
                    if (state == ARB_BUSY_I) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = m_ready ? m_rdata : '0;
                    end else begin
                        d_done_nxt = 1'b1;
                        if (!m_we) begin
                            d_rdata_nxt = m_ready ? m_rdata : '0;
                        end
                    end
                end else begin
                    timer_inc = 1'b1;
                end
            end

            default: begin
                m_req_nxt = 1'b0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            err      <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            m_req    <= m_req_nxt;
            m_we     <= m_we_nxt;
            m_addr   <= m_addr_nxt;
            m_wdata  <= m_wdata_nxt;
            if_done  <= if_done_nxt;
            d_done   <= d_done_nxt;
            err      <= err_nxt;
            if_rdata <= if_rdata_nxt;
            d_rdata  <= d_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a directed table of single
// transactions, hand-written contention/masking/reset sequences, and a random
// phase, all checked every cycle against a transaction-rule reference model.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .err      (err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready)
    );

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // ---------------- memory responder ----------------
    bit [31:0] mem [bit [31:0]];
    int lat  = 1;
    bit hang = 1'b0;
    int mcnt = 0;

    function automatic bit [31:0] mem_read(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive_mem();
        if (m_req) begin
            mcnt++;
            if (!hang && mcnt >= lat) begin
                m_ready = 1'b1;
                if (m_we) begin
                    mem[m_addr] = m_wdata;
                    m_rdata = $urandom;
                end else begin
                    m_rdata = mem_read(m_addr);
                end
            end else begin
                m_ready = 1'b0;
                m_rdata = $urandom;
            end
        end else begin
            // Noise on the response bus while no request is open.
            mcnt    = 0;
            m_ready = 1'($urandom_range(0, 1));
            m_rdata = $urandom;
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = fetch, 2 = data
    int        owner, waited, starve;
    logic        e_m_req, e_m_we, e_if_done, e_d_done, e_err;
    logic [31:0] e_m_addr, e_m_wdata, e_if_rdata, e_d_rdata;

    task automatic model_reset();
        owner = 0; waited = 0; starve = 0;
        e_m_req = 0; e_m_we = 0; e_if_done = 0; e_d_done = 0; e_err = 0;
        e_m_addr = 0; e_m_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
    endtask

    task automatic model_step();
        bit i_ok, d_ok, take_i;
        i_ok = if_req && !e_if_done;
        d_ok = d_req && !e_d_done;
        e_if_done = 0; e_d_done = 0; e_err = 0;
        if (owner == 0) begin
            if (i_ok || d_ok) begin
                take_i = i_ok && (!d_ok || starve == STARVE);
                if (take_i) begin
                    owner = 1; e_m_addr = if_addr; e_m_we = 0; e_m_wdata = 0;
                    starve = 0;
                end else begin
                    owner = 2; e_m_addr = d_addr; e_m_we = d_we; e_m_wdata = d_wdata;
                    starve = if_req ? ((starve < STARVE) ? starve + 1 : STARVE) : 0;
                end
                e_m_req = 1; waited = 0;
            end else begin
                e_m_req = 0;
            end
        end else if (m_ready || waited == TMO - 1) begin
            if (owner == 1) begin
                e_if_done = 1;
                e_if_rdata = m_ready ? m_rdata : 32'h0;
            end else begin
                e_d_done = 1;
                if (!e_m_we) e_d_rdata = m_ready ? m_rdata : 32'h0;
            end
            e_err = !m_ready; e_m_req = 0; owner = 0;
        end else begin
            waited++;
        end
    endtask

    int done_log[$];

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        cycle++;
        check($sformatf("outputs@cycle%0d", cycle),
              {m_req, m_we, m_addr, m_wdata, if_done, if_rdata, d_done, d_rdata, err},
              {e_m_req, e_m_we, e_m_addr, e_m_wdata, e_if_done, e_if_rdata, e_d_done, e_d_rdata, e_err});
        if (if_done) done_log.push_back(1);
        if (d_done)  done_log.push_back(2);
        drive_mem();
    endtask

    // ---------------- directed transaction table ----------------
    typedef struct {
        bit        is_d;
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        do_pre;
        bit [31:0] pre;
        int        lat;
        bit        hang;
        int        exp_cyc;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input int k);
        vec_t v;
        int   cyc;
        bit   got, bus_ok, other, e;
        bit [31:0] rdat;
        v = vecs[k];
        if (v.do_pre) mem[v.addr] = v.pre;
        lat = v.lat; hang = v.hang;
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        cyc = 0; got = 0; bus_ok = 1; other = 0; e = 0; rdat = 0;
        while (!got && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                // Inputs moving after the grant must not reach the bus.
                if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata;
            end
            if (m_req && (m_addr !== v.addr || m_we !== v.we ||
                          (v.we && m_wdata !== v.wdata))) bus_ok = 0;
            other |= v.is_d ? if_done : d_done;
            if (v.is_d ? d_done : if_done) begin
                got = 1; e = err; rdat = v.is_d ? d_rdata : if_rdata;
            end
        end
        if_req = 0; d_req = 0;
        check($sformatf("vec%0d_done_cycle", k), 160'(got ? cyc : -1), 160'(v.exp_cyc));
        check($sformatf("vec%0d_rdata", k), 160'(rdat), 160'(v.exp_rdata));
        check($sformatf("vec%0d_err", k), 160'(e), 160'(v.exp_err));
        check($sformatf("vec%0d_bus_stable", k), 160'(bus_ok), 160'(1));
        check($sformatf("vec%0d_other_done", k), 160'(other), 160'(0));
        tick();
        tick();
    endtask

    int exp_order[10];

    initial begin
        int cnt;
        bit seen;

        vecs[0] = '{0, 0, 32'h10,  32'h0,        1, 32'h8C220004, 1, 0, 2,  32'h8C220004, 0};
        vecs[1] = '{1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        3, 0, 4,  32'h0,        0};
        vecs[2] = '{1, 0, 32'h100, 32'h0,        0, 32'h0,        3, 0, 4,  32'hDEADBEEF, 0};
        vecs[3] = '{0, 0, 32'h200, 32'h0,        1, 32'h12345678, 5, 0, 6,  32'h12345678, 0};
        vecs[4] = '{1, 0, 32'h300, 32'h0,        1, 32'hCAFEF00D, 1, 0, 2,  32'hCAFEF00D, 0};
        vecs[5] = '{1, 1, 32'h300, 32'h0BADC0DE, 0, 32'h0,        2, 0, 3,  32'hCAFEF00D, 0};
        vecs[6] = '{1, 0, 32'h300, 32'h0,        0, 32'h0,        4, 0, 5,  32'h0BADC0DE, 0};
        vecs[7] = '{0, 0, 32'h400, 32'h0,        1, 32'h11111111, 1, 1, 65, 32'h0,        1};
        vecs[8] = '{1, 0, 32'h500, 32'h0,        1, 32'h22222222, 1, 1, 65, 32'h0,        1};
        vecs[9] = '{0, 0, 32'h10,  32'h0,        0, 32'h0,        1, 0, 2,  32'h8C220004, 0};
        exp_order = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_rdata = 0; m_ready = 0;
        model_reset();
        tick();
        tick();
        check("reset_state",
              {m_req, m_we, m_addr, m_wdata, if_done, if_rdata, d_done, d_rdata, err}, 160'(0));
        rst = 0;

        for (int k = 0; k < 10; k++) run_vec(k);

        // Contention: fetch withdrawn only during data done cycles.
        done_log.delete();
        lat = 1; hang = 0;
        if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
        for (int c = 0; c < 300 && done_log.size() < 10; c++) begin
            tick();
            if_req = !d_done;
        end
        if_req = 0; d_req = 0;
        for (int k = 0; k < 10; k++)
            check($sformatf("grant_order[%0d]", k),
                  160'((k < done_log.size()) ? done_log[k] : 0), 160'(exp_order[k]));
        tick();
        tick();

        // Done-cycle masking: fetch held one cycle past if_done.
        lat = 1;
        if_req = 1; if_addr = 32'h40;
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h80;
        tick();
        check("mask_if_done", 160'(if_done), 160'(1));
        tick();
        check("mask_grants_data", {m_req, m_we, m_addr}, {1'b1, 1'b0, 32'h80});
        if_req = 0;
        seen = 0; cnt = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (if_done) cnt++;
            if (d_done) seen = 1;
        end
        d_req = 0;
        check("mask_d_done_seen", 160'(seen), 160'(1));
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if_done) cnt++;
        end
        check("mask_no_second_fetch", 160'(cnt), 160'(0));

        // Reset while a data load is outstanding.
        hang = 1;
        d_req = 1; d_we = 0; d_addr = 32'h600;
        for (int c = 0; c < 4; c++) tick();
        check("rst_pre_busy", 160'(m_req), 160'(1));
        rst = 1;
        #1;
        check("rst_async", {m_req, d_done, err, if_done}, 160'(0));
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 0; hang = 0; lat = 2;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (d_done) begin
                cnt++;
                d_req = 0;
            end
        end
        check("rst_single_done_after", 160'(cnt), 160'(1));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (if_req) begin
                if (if_done) if_req = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 7) == 0) if_addr = $urandom;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (d_req) begin
                if (d_done) d_req = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 7) == 0) begin
                    d_addr = $urandom; d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom & 32'h0000_00FC; d_wdata = $urandom;
            end
            if (!m_req) begin
                lat  = $urandom_range(1, 4);
                hang = ($urandom_range(0, 39) == 0);
            end
        end
        if_req = 0; d_req = 0; hang = 0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            if (!m_req && !e_m_req && owner == 0) seen = 1;
        end
        check("drain_idle", 160'(seen), 160'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the pipelined CPU.
- Grants one requester at a time and drives the shared memory handshake.
- Returns registered read data and a one-cycle done pulse per transaction.
- The pipeline holds its stage (stall) while its request is outstanding.

Parameters:
- ADDR_W, 32, address width (matches ADDR_LEN).
- DATA_W, 32, data width (matches DATA_LEN).
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits; the next grant is then forced to fetch.
- TIMEOUT, 64, maximum cycles a granted transaction waits for m_ready before it is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_done  out  1  one-cycle completion pulse for the fetch.
- if_rdata  out  DATA_W  fetched instruction; valid while if_done is high, held afterwards.
- d_req  in  1  data request; level, held until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle completion pulse for the data access.
- d_rdata  out  DATA_W  load data; updated only on load completion.
- err  out  1  one-cycle pulse, coincident with the done pulse, when a transaction timed out.
- m_req  out  1  memory request; held high until m_ready is sampled high.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid in the cycle m_ready is high.
- m_ready  in  1  memory completion, sampled only while m_req is high.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - All outputs 0, including if_rdata and d_rdata.
  - starve_cnt = 0; timer = 0.
  - Any in-flight transaction is discarded; no done pulse follows.
- FSM states: IDLE, BUSY_I, BUSY_D. All outputs are registered.
- IDLE:
  - Eligible requester = req high AND its done output low in the current cycle. This masks the requester for the cycle its done pulse is visible.
  - Both eligible: fetch wins if starve_cnt == STARVE_LIMIT; otherwise data wins.
  - On grant: latch address, write data and we into the m_* registers. Set m_req = 1. Go to BUSY_I or BUSY_D. Clear timer.
  - Neither eligible: m_req = 0; stay in IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while if_req is high.
  - Clears on every fetch grant.
  - Clears on any data grant made while if_req is low.
- BUSY_x, m_ready sampled 1:
  - Next edge: m_req = 0; x_done = 1 for exactly one cycle; state = IDLE.
  - Read (fetch, or data load with m_we = 0): x_rdata <= m_rdata.
  - Store: d_rdata unchanged.
- BUSY_x, m_ready sampled 0:
  - timer increments.
  - When timer reaches TIMEOUT-1 with no m_ready: next edge gives x_done = 1, err = 1, x_rdata = 0 (reads only), m_req = 0, state = IDLE.
- Latency:
  - Request seen in IDLE at edge N → m_req high from N+1.
  - m_ready high in cycle N+1 → done high in cycle N+2. Minimum 2 cycles.
  - Back-to-back grants to the other requester: done cycle plus one IDLE cycle; the next m_req rises the edge after IDLE.
- m_addr, m_we and m_wdata are constant for the whole time m_req is high. Input changes during BUSY are ignored.
- A req dropped mid-transaction is a protocol violation. The transaction still completes and the done pulse is still emitted.
- m_ready while m_req is low is ignored.
- Simultaneous first requests after reset: data wins, because starve_cnt = 0.

Decomposition:
- Into defines.v:
  - FSM state encodings ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D (2-bit).
  - Default STARVE_LIMIT and TIMEOUT constants.
  - Widths from the existing ADDR_LEN / DATA_LEN.
- One natural sub-module, arb_timeout_counter: loadable/clearable counter with a terminal-count flag. Used for both the watchdog timer and the saturating starve count.

Test Plan:
- Single fetch, memory ready 1 cycle after m_req: if_req=1, if_addr=0x00000010, m_rdata=0x8C220004 → m_addr=0x10, m_we=0, if_done pulses in cycle 2, if_rdata=0x8C220004, d_done never asserts.
- Store then load, memory latency 3 cycles:
  - Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → m_we=1 and m_wdata stable for 3 cycles, d_done after 3 cycles, d_rdata unchanged.
  - Load from 0x100 with m_rdata=0xDEADBEEF → d_rdata=0xDEADBEEF.
- Contention and starvation guard, STARVE_LIMIT=4: if_req and d_req held continuously → grant order D,D,D,D,I,D,D,D,D,I; if_done occurs at the 5th completion.
- Timeout, TIMEOUT=64: d_req load, m_ready held 0 → exactly 64 cycles later d_done=1, err=1, d_rdata=0; the FSM returns to IDLE and the next fetch is served normally.
- Reset mid-operation: assert rst while in BUSY_D with m_req=1 → m_req, d_done and err are 0 immediately; after release, with d_req still high, a fresh grant is issued and exactly one d_done follows.
- Done-cycle masking: if_req held one cycle past if_done, with a 1-cycle memory → no second m_req for the fetch; the IDLE cycle grants a pending d_req instead.
